ps2_rx_frame: RTL and testbench

PS/2 receive front end that deserializes the keyboard's ps2c/ps2d lines into 8-bit scan codes. Output is a one-cycle rx_done_tick plus held dout byte, which feed the downstream keyboard decoder's rx_done_tick/keycodeout inputs directly. Includes input synchronization, clock-line glitch filtering, frame checking and a stalled-frame timeout. Runs on the 100 MHz system clock.

---
 rtl/ps2_rx_frame.sv | 164 ++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 receive front end that turns the keyboard's ps2c/ps2d
// lines into 8-bit scan codes.
// It synchronizes both pins, glitch-filters the clock line and checks each
// frame. A frame that stalls mid-way is aborted after a timeout.
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        synchronous, active-high reset
//   ps2c, ps2d   asynchronous PS/2 clock/data pins, both idle high
//   rx_en        allows a new frame to start
//   rx_done_tick one-cycle pulse when a valid frame is received
//   dout         last valid scan code, held until the next valid frame
//   frame_err    one-cycle pulse when a frame is rejected or aborted
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   When defined, a frame also needs odd parity over the data and parity bits.
//   When undefined, the parity bit is received but ignored.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    logic                  c_meta_q, c_sync_q, d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fclk_q, fclk_d;
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [9:0]            b_q, b_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  rx_done_q, rx_done_d;
    logic [7:0]            dout_q, dout_d;
    logic                  frame_err_q, frame_err_d;

    logic                  fall_c;
    logic [9:0]            b_shift_c;
    logic                  frame_ok_c;

    // State registers; synchronizers and filter reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta_q    <= 1'b1;
            c_sync_q    <= 1'b1;
            d_meta_q    <= 1'b1;
            d_sync_q    <= 1'b1;
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            b_q         <= 10'd0;
            tmo_q       <= '0;
            rx_done_q   <= 1'b0;
            dout_q      <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            c_meta_q    <= ps2c;
            c_sync_q    <= c_meta_q;
            d_meta_q    <= ps2d;
            d_sync_q    <= d_meta_q;
            filt_q      <= filt_d;
            fclk_q      <= fclk_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_q         <= b_d;
            tmo_q       <= tmo_d;
            rx_done_q   <= rx_done_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Clock filter: the level changes only after FILTER_LEN equal samples.
    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q};
        fclk_d = fclk_q;
        if (&filt_d) begin
            fclk_d = 1'b1;
        end else if (~|filt_d) begin
            fclk_d = 1'b0;
        end
        fall_c = fclk_q & ~fclk_d;
    end

    // Frame check on the fully shifted word (stop in bit 9, parity in bit 8).
    always_comb begin
        b_shift_c  = {d_sync_q, b_q[9:1]};
`ifdef PS2_PARITY_CHECK_EN
        frame_ok_c = b_shift_c[9] & (^b_shift_c[8:0]);
`else
        frame_ok_c = b_shift_c[9];
`endif
    end

    // Receive FSM. The result pulses are registered on the edge that enters LOAD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_d         = b_q;
        tmo_d       = tmo_q;
        rx_done_d   = 1'b0;
        dout_d      = dout_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall_c && rx_en && !d_sync_q) begin
                    state_d = SHIFT;
                    cnt_d   = 4'd9;
                end
            end
            SHIFT: begin
                if (fall_c) begin
                    b_d   = b_shift_c;
                    tmo_d = '0;
                    if (cnt_q == 4'd0) begin
                        state_d = LOAD;
                        if (frame_ok_c) begin
                            rx_done_d = 1'b1;
                            dout_d    = b_shift_c[7:0];
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Stalled frame: drop the partial data, keep dout.
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_done_tick = rx_done_q;
    assign dout         = dout_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Testbench for ps2_rx_frame: directed and random PS/2 frames checked
// against a frame-level reference model (expected pulses and held byte).
module tb_ps2_rx_frame;

    localparam int unsigned FL  = 8;
    localparam int unsigned TMO = 1000;
    localparam int          HP  = 40;

    logic       clk;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;
    logic [7:0] exp_dout = 8'h00;

    ps2_rx_frame #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .rx_en       (rx_en),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done_tick) n_done++;
        if (frame_err) n_err++;
        if (rx_done_tick && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the first nbits bits (LSB first) as PS/2 clock periods.
    // mode 2 drops rx_en right after the start bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            wait_cyc(HP);
            ps2c = 1'b0;
            wait_cyc(HP);
            ps2c = 1'b1;
            if (mode == 2 && i == 0) rx_en = 1'b0;
        end
        ps2d = 1'b1;
    endtask

    // Send one full frame and check pulses and dout against the frame rules.
    // mode 0: normal, 1: rx_en low throughout, 2: rx_en dropped mid-frame.
    task automatic run_frame(input logic [7:0] data, input logic par, input logic stop, input int mode);
        int d0, e0;
        logic ok;
        d0 = n_done;
        e0 = n_err;
        rx_en = (mode == 1) ? 1'b0 : 1'b1;
        send_bits({stop, par, data, 1'b0}, 11, mode);
        wait_cyc(4 * HP);
        ok = stop;
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && (((^data) ^ par) == 1'b1);
`endif
        if (mode == 1) begin
            check("blocked_done", 32'(n_done - d0), 32'd0);
            check("blocked_err", 32'(n_err - e0), 32'd0);
        end else begin
            if (ok) exp_dout = data;
            check("done_cnt", 32'(n_done - d0), ok ? 32'd1 : 32'd0);
            check("err_cnt", 32'(n_err - e0), ok ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        check("dout", 32'(dout), 32'(exp_dout));
        rx_en = 1'b1;
    endtask

    initial begin
        int d0, e0;
        logic [7:0] rd;
        logic rp, rs;
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        // Directed frames
        run_frame(8'h15, 1'b0, 1'b1, 0);
        run_frame(8'hF0, 1'b1, 1'b1, 0);
        run_frame(8'h15, 1'b0, 1'b1, 0);
        run_frame(8'h74, 1'b1, 1'b0, 0);
        run_frame(8'h15, 1'b1, 1'b1, 0);

        // Stalled frame: start plus three data bits, then silence
        d0 = n_done;
        e0 = n_err;
        send_bits({1'b1, 1'b0, 8'h75, 1'b0}, 4, 0);
        wait_cyc(TMO + 10 + FL + 4);
        check("tmo_err", 32'(n_err - e0), 32'd1);
        check("tmo_done", 32'(n_done - d0), 32'd0);
        @(negedge clk);
        check("tmo_dout", 32'(dout), 32'(exp_dout));
        run_frame(8'h75, 1'b0, 1'b1, 0);

        // Short clock glitch with data low must not start a frame
        d0 = n_done;
        e0 = n_err;
        ps2d = 1'b0;
        ps2c = 1'b0;
        wait_cyc(FL - 2);
        ps2c = 1'b1;
        wait_cyc(50);
        ps2d = 1'b1;
        wait_cyc(20);
        check("glitch_done", 32'(n_done - d0), 32'd0);
        check("glitch_err", 32'(n_err - e0), 32'd0);
        run_frame(8'h1C, 1'b0, 1'b1, 0);

        // Reset after the fifth bit of a frame
        d0 = n_done;
        e0 = n_err;
        send_bits({1'b1, 1'b1, 8'hA3, 1'b0}, 5, 0);
        reset = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        check("mrst_dout", 32'(dout), 32'h00);
        check("mrst_done", 32'(rx_done_tick), 32'd0);
        check("mrst_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        exp_dout = 8'h00;
        wait_cyc(4 * HP);
        check("mrst_done_cnt", 32'(n_done - d0), 32'd0);
        check("mrst_err_cnt", 32'(n_err - e0), 32'd0);
        run_frame(8'h5A, 1'b1, 1'b1, 0);

        // rx_en gating
        run_frame(8'h33, 1'b1, 1'b1, 1);
        run_frame(8'h6B, 1'b0, 1'b1, 2);

        // Random frames with occasional parity/stop errors
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 255));
            rp = ~(^rd);
            if ($urandom_range(0, 9) < 3) rp = ~rp;
            rs = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            run_frame(rd, rp, rs, 0);
        end

        check("never_both", 32'(n_both), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
